wbu_pipe: RTL and testbench
===========================

WBU_PIPE -- requirements
Module: wbu_pipe

Interface
REQ-001 SHALL have parameters: DATA_W, default `DATA_WIDTH, GPR data width; ADDR_W, default `ADDR_WIDTH, PC width; GPRS_W, default `GPRS_WIDTH, register-id width; DEPTH, default 4, buffer entries (power of two, >=2); CNT_W, default 32, retire-counter width.
REQ-002 SHALL use one clock and a synchronous, active-high reset: i_sys_clk  in  1  clock; i_sys_rst  in  1  synchronous active-high reset.
REQ-003 i_exu_valid  in  1  upstream result valid; o_wbu_ready  out  1  buffer can accept.
REQ-004 i_idu_ctr_reg_wr_en  in  1  GPR write request; i_idu_ctr_reg_wr_src  in  `ARGS_WIDTH  source select.
REQ-005 i_ifu_pc  in  ADDR_W; i_exu_res  in  DATA_W; i_ram_res  in  DATA_W; i_csr_res  in  DATA_W; i_gpr_wr_id  in  GPRS_W  destination.
REQ-006 i_gpr_ready  in  1  register-file port free this cycle; i_flush  in  1  discard all buffered entries.
REQ-007 o_sys_valid  out  1  head entry present; o_wbu_gpr_wr_en  out  1; o_wbu_gpr_wr_id  out  GPRS_W; o_wbu_gpr_wr_data  out  DATA_W.
REQ-008 o_wbu_busy_mask  out  2**GPRS_W  pending-write scoreboard; o_wbu_retire_cnt  out  CNT_W  retired-entry count.

Function
REQ-009 Enqueue SHALL occur on a rising edge when i_exu_valid && o_wbu_ready && !i_flush.
REQ-010 Data SHALL be resolved at enqueue: ALU->i_exu_res, MEM->i_ram_res, PC->i_ifu_pc zero-extended to DATA_W, CSR->i_csr_res, any other code->zero.
REQ-011 Each entry SHALL store {wr_en, id, data}; wr_en stored as i_idu_ctr_reg_wr_en && (i_gpr_wr_id != 0).
REQ-012 Entries with stored wr_en=0 SHALL still be enqueued and retired in order.
REQ-013 o_wbu_ready SHALL equal (count < DEPTH) from registered state; a full buffer SHALL NOT accept even if a dequeue happens that cycle.
REQ-014 o_sys_valid SHALL equal (count != 0).
REQ-015 Dequeue SHALL occur when o_sys_valid && i_gpr_ready && !i_flush; one entry per cycle, oldest first.
REQ-016 o_wbu_gpr_wr_en SHALL be head.wr_en && o_sys_valid && i_gpr_ready && !i_flush, combinational; o_wbu_gpr_wr_id/o_wbu_gpr_wr_data SHALL be head id/data when o_wbu_gpr_wr_en, else zero.
REQ-017 Result latency SHALL be one cycle minimum: enqueue at edge N -> GPR write visible in cycle N+1 if i_gpr_ready.
REQ-018 Simultaneous enqueue and dequeue (non-full, non-empty) SHALL leave count unchanged.
REQ-019 Read/write pointers SHALL wrap modulo DEPTH.
REQ-020 i_flush SHALL, at the next edge, set count and both pointers to zero; flush overrides enqueue and dequeue in the same cycle.
REQ-021 o_wbu_busy_mask bit k SHALL be 1 iff some buffered entry has wr_en=1 and id=k; bit 0 SHALL always be 0; combinational from buffer state.
REQ-022 o_wbu_retire_cnt SHALL increment by 1 per dequeue (writing or not), wrap at 2**CNT_W, and not be cleared by i_flush.

Reset
REQ-023 On i_sys_rst: count, pointers, o_wbu_retire_cnt SHALL be zero; hence o_sys_valid=0, o_wbu_ready=1, o_wbu_gpr_wr_en=0, id/data=0, busy mask=0 from the first cycle after reset.
REQ-024 Reset SHALL take priority over flush, enqueue and dequeue; entry payload storage need not be reset.

Structure
REQ-025 Package wbu_pkg SHALL hold the entry struct and the source-code constants, including the new CSR code alongside the existing ALU/MEM/PC codes.
REQ-026 Storage and pointer/count logic SHALL be one sub-module, wbu_fifo, parametrised by DEPTH and entry type; source muxing, scoreboard and counter stay in wbu_pipe.

Verification
REQ-027 Reset then src=ALU, id=5, exu_res=0x1234, wr_en=1, gpr_ready=1 -> next cycle wr_en=1, id=5, data=0x1234, retire_cnt=1.
REQ-028 gpr_ready=0, DEPTH=4, push 5 valid results -> ready drops after 4th, 5th held upstream, busy mask has the 4 ids; gpr_ready=1 -> 4 writes in order over 4 cycles.
REQ-029 Write to id=0 with wr_en=1 src=MEM -> no GPR write, retire_cnt increments, busy mask bit 0 stays 0.
REQ-030 Buffer holding 3 entries, assert i_flush with simultaneous valid input -> next cycle o_sys_valid=0, busy mask=0, retire_cnt unchanged, input not stored.
REQ-031 Unknown src code with exu_res=0xFFFF -> written data 0; src=PC with pc=0x8000_0004 -> data 0x8000_0004.
REQ-032 Count wrap: CNT_W=4, retire 17 entries -> retire_cnt=1; reset mid-stream with 2 entries -> outputs as REQ-023 next cycle.

Source files
------------

// File: rtl/wbu_pkg.sv
// Shared definitions for the write-back unit: default widths, result-source
// codes and the default-width buffer entry layout.
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 32
`endif
`ifndef GPRS_WIDTH
`define GPRS_WIDTH 5
`endif
`ifndef ARGS_WIDTH
`define ARGS_WIDTH 3
`endif

package wbu_pkg;

  localparam int SRC_W = `ARGS_WIDTH;

  // Result-source select codes; any other value resolves to zero data.
  localparam logic [SRC_W-1:0] SRC_ALU = SRC_W'(0);
  localparam logic [SRC_W-1:0] SRC_MEM = SRC_W'(1);
  localparam logic [SRC_W-1:0] SRC_PC  = SRC_W'(2);
  localparam logic [SRC_W-1:0] SRC_CSR = SRC_W'(3);

  typedef struct packed {
    logic                   wr_en;
    logic [`GPRS_WIDTH-1:0] id;
    logic [`DATA_WIDTH-1:0] data;
  } wbu_entry_t;

endpackage

// File: rtl/wbu_fifo.sv
// Circular result buffer: payload storage, read/write pointers and occupancy.
// Payload storage is not reset; only pointers and count are.
module wbu_fifo #(
  parameter int  DEPTH   = 4,
  parameter type entry_t = logic
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             push,
  input  logic             pop,
  input  entry_t           wr_entry,
  output entry_t           head,
  output entry_t           entries [DEPTH],
  output logic [DEPTH-1:0] occupied,
  output logic             valid,
  output logic             ready
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  entry_t             mem [DEPTH];
  logic [PTR_W-1:0]   wr_ptr;
  logic [PTR_W-1:0]   rd_ptr;
  logic [CNT_W-1:0]   count;
  logic [PTR_W-1:0]   offset;

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= wr_entry;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // A slot is live when its distance from the read pointer is below count.
  always_comb begin
    occupied = '0;
    offset   = '0;
    for (int i = 0; i < DEPTH; i++) begin
      offset      = PTR_W'(i) - rd_ptr;
      occupied[i] = ({1'b0, offset} < count);
    end
  end

  assign head    = mem[rd_ptr];
  assign entries = mem;
  assign valid   = (count != '0);
  assign ready   = (count < CNT_W'(DEPTH));

endmodule

// File: rtl/wbu_pipe.sv
// Write-back buffer: resolves the result source at enqueue, drains one entry
// per cycle to the GPR port, tracks pending writes and counts retirements.
module wbu_pipe
  import wbu_pkg::*;
#(
  parameter int DATA_W = `DATA_WIDTH,
  parameter int ADDR_W = `ADDR_WIDTH,
  parameter int GPRS_W = `GPRS_WIDTH,
  parameter int DEPTH  = 4,
  parameter int CNT_W  = 32
) (
  input  logic                   i_sys_clk,
  input  logic                   i_sys_rst,
  input  logic                   i_exu_valid,
  output logic                   o_wbu_ready,
  input  logic                   i_idu_ctr_reg_wr_en,
  input  logic [`ARGS_WIDTH-1:0] i_idu_ctr_reg_wr_src,
  input  logic [ADDR_W-1:0]      i_ifu_pc,
  input  logic [DATA_W-1:0]      i_exu_res,
  input  logic [DATA_W-1:0]      i_ram_res,
  input  logic [DATA_W-1:0]      i_csr_res,
  input  logic [GPRS_W-1:0]      i_gpr_wr_id,
  input  logic                   i_gpr_ready,
  input  logic                   i_flush,
  output logic                   o_sys_valid,
  output logic                   o_wbu_gpr_wr_en,
  output logic [GPRS_W-1:0]      o_wbu_gpr_wr_id,
  output logic [DATA_W-1:0]      o_wbu_gpr_wr_data,
  output logic [2**GPRS_W-1:0]   o_wbu_busy_mask,
  output logic [CNT_W-1:0]       o_wbu_retire_cnt
);

  typedef struct packed {
    logic              wr_en;
    logic [GPRS_W-1:0] id;
    logic [DATA_W-1:0] data;
  } entry_t;

  entry_t           entry_p0;
  entry_t           head_p1;
  entry_t           entries_p1 [DEPTH];
  logic [DEPTH-1:0] occupied_p1;
  logic             vld_p1;
  logic             fifo_ready;
  logic             push;
  logic             pop;

  function automatic logic [DATA_W-1:0] resolve_src(
    input logic [SRC_W-1:0]  src,
    input logic [DATA_W-1:0] exu_res,
    input logic [DATA_W-1:0] ram_res,
    input logic [DATA_W-1:0] csr_res,
    input logic [ADDR_W-1:0] pc
  );
    case (src)
      SRC_ALU: return exu_res;
      SRC_MEM: return ram_res;
      SRC_PC:  return DATA_W'(pc);
      SRC_CSR: return csr_res;
      default: return '0;
    endcase
  endfunction

  // Stage p0: resolve the entry payload at enqueue time.
  always_comb begin
    entry_p0       = '0;
    entry_p0.wr_en = i_idu_ctr_reg_wr_en && (i_gpr_wr_id != '0);
    entry_p0.id    = i_gpr_wr_id;
    entry_p0.data  = resolve_src(i_idu_ctr_reg_wr_src, i_exu_res, i_ram_res,
                                 i_csr_res, i_ifu_pc);
  end

  assign push = i_exu_valid && fifo_ready && !i_flush;
  assign pop  = vld_p1 && i_gpr_ready && !i_flush;

  wbu_fifo #(
    .DEPTH   (DEPTH),
    .entry_t (entry_t)
  ) u_fifo (
    .clk      (i_sys_clk),
    .rst      (i_sys_rst),
    .flush    (i_flush),
    .push     (push),
    .pop      (pop),
    .wr_entry (entry_p0),
    .head     (head_p1),
    .entries  (entries_p1),
    .occupied (occupied_p1),
    .valid    (vld_p1),
    .ready    (fifo_ready)
  );

  // Stage p1: drain the head entry to the register-file port.
  always_comb begin
    o_wbu_gpr_wr_en   = head_p1.wr_en && pop;
    o_wbu_gpr_wr_id   = '0;
    o_wbu_gpr_wr_data = '0;
    if (o_wbu_gpr_wr_en) begin
      o_wbu_gpr_wr_id   = head_p1.id;
      o_wbu_gpr_wr_data = head_p1.data;
    end
  end

  always_comb begin
    o_wbu_busy_mask = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (occupied_p1[i] && entries_p1[i].wr_en) begin
        o_wbu_busy_mask[entries_p1[i].id] = 1'b1;
      end
    end
    o_wbu_busy_mask[0] = 1'b0;
  end

  // Retirement count survives flushes; only reset clears it.
  always_ff @(posedge i_sys_clk) begin
    if (i_sys_rst) begin
      o_wbu_retire_cnt <= '0;
    end else if (pop) begin
      o_wbu_retire_cnt <= o_wbu_retire_cnt + CNT_W'(1);
    end
  end

  assign o_wbu_ready = fifo_ready;
  assign o_sys_valid = vld_p1;

endmodule

// File: tb/tb_wbu_pipe.sv
// Scoreboard bench for wbu_pipe: a reference queue is updated from driven
// stimulus and compared against the GPR port, flags, busy mask and counter.
module tb_wbu_pipe;

  logic        clk = 1'b0;
  logic        rst;
  logic        exu_valid;
  logic        wbu_ready;
  logic        wr_en_in;
  logic [2:0]  wr_src;
  logic [31:0] ifu_pc;
  logic [31:0] exu_res;
  logic [31:0] ram_res;
  logic [31:0] csr_res;
  logic [4:0]  gpr_wr_id;
  logic        gpr_ready;
  logic        flush;
  logic        sys_valid;
  logic        gpr_wr_en;
  logic [4:0]  gpr_wr_id_out;
  logic [31:0] gpr_wr_data;
  logic [31:0] busy_mask;
  logic [3:0]  retire_cnt;

  typedef struct {
    logic        we;
    logic [4:0]  id;
    logic [31:0] data;
  } ent_t;

  ent_t q[$];
  int   rcnt;
  int   n_chk;
  int   n_pass;

  always #5 clk = ~clk;

  wbu_pipe #(.CNT_W(4)) dut (
    .i_sys_clk            (clk),
    .i_sys_rst            (rst),
    .i_exu_valid          (exu_valid),
    .o_wbu_ready          (wbu_ready),
    .i_idu_ctr_reg_wr_en  (wr_en_in),
    .i_idu_ctr_reg_wr_src (wr_src),
    .i_ifu_pc             (ifu_pc),
    .i_exu_res            (exu_res),
    .i_ram_res            (ram_res),
    .i_csr_res            (csr_res),
    .i_gpr_wr_id          (gpr_wr_id),
    .i_gpr_ready          (gpr_ready),
    .i_flush              (flush),
    .o_sys_valid          (sys_valid),
    .o_wbu_gpr_wr_en      (gpr_wr_en),
    .o_wbu_gpr_wr_id      (gpr_wr_id_out),
    .o_wbu_gpr_wr_data    (gpr_wr_data),
    .o_wbu_busy_mask      (busy_mask),
    .o_wbu_retire_cnt     (retire_cnt)
  );

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
  endtask

  // One cycle: apply inputs, compare against the reference, then advance it.
  task automatic drive(input logic v, input logic [2:0] src, input logic we,
                       input logic [4:0] id, input logic [31:0] val,
                       input logic gr, input logic fl);
    logic        nonempty, full, accept, deq, exp_we;
    logic [4:0]  exp_id;
    logic [31:0] exp_data, exp_mask;
    ent_t        e;
    exu_valid = v;  wr_src = src;  wr_en_in = we;  gpr_wr_id = id;
    exu_res = val;  ram_res = val ^ 32'hA5A5_0000;
    csr_res = val ^ 32'h0000_5A5A;  ifu_pc = val + 32'd4;
    gpr_ready = gr;  flush = fl;
    #1;
    nonempty = (q.size() != 0);
    full     = (q.size() >= 4);
    exp_we = 1'b0;  exp_id = '0;  exp_data = '0;
    if (nonempty && q[0].we && gr && !fl) begin
      exp_we = 1'b1;  exp_id = q[0].id;  exp_data = q[0].data;
    end
    exp_mask = '0;
    foreach (q[i]) if (q[i].we) exp_mask[q[i].id] = 1'b1;
    chk("sys_valid", 64'(sys_valid), 64'(nonempty));
    chk("wbu_ready", 64'(wbu_ready), 64'(!full));
    chk("gpr_wr_en", 64'(gpr_wr_en), 64'(exp_we));
    chk("gpr_wr_id", 64'(gpr_wr_id_out), 64'(exp_id));
    chk("gpr_wr_data", 64'(gpr_wr_data), 64'(exp_data));
    chk("busy_mask", 64'(busy_mask), 64'(exp_mask));
    chk("retire_cnt", 64'(retire_cnt), 64'(rcnt % 16));
    accept = v && !full && !fl;
    deq    = nonempty && gr && !fl;
    e.we = we && (id != 5'd0);
    e.id = id;
    case (src)
      3'd0:    e.data = val;
      3'd1:    e.data = val ^ 32'hA5A5_0000;
      3'd2:    e.data = val + 32'd4;
      3'd3:    e.data = val ^ 32'h0000_5A5A;
      default: e.data = 32'd0;
    endcase
    @(posedge clk);
    if (fl) q.delete();
    else begin
      if (deq) begin
        void'(q.pop_front());
        rcnt++;
      end
      if (accept) q.push_back(e);
    end
    #1;
  endtask

  task automatic idle(input logic gr);
    drive(1'b0, 3'd0, 1'b0, 5'd0, 32'd0, gr, 1'b0);
  endtask

  // Reset with a valid input present: reset must win over enqueue.
  task automatic do_reset();
    rst = 1'b1;  exu_valid = 1'b1;  wr_en_in = 1'b1;  gpr_wr_id = 5'd9;
    gpr_ready = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;  exu_valid = 1'b0;
    q.delete();
    rcnt = 0;
  endtask

  initial begin
    n_chk = 0;  n_pass = 0;  rcnt = 0;
    rst = 1'b1;  exu_valid = 1'b0;  wr_en_in = 1'b0;  wr_src = '0;
    ifu_pc = '0;  exu_res = '0;  ram_res = '0;  csr_res = '0;
    gpr_wr_id = '0;  gpr_ready = 1'b0;  flush = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    // Reset state, then a single ALU write with one-cycle latency.
    idle(1'b1);
    drive(1'b1, 3'd0, 1'b1, 5'd5, 32'h1234, 1'b1, 1'b0);
    idle(1'b1);
    chk("first_retire", 64'(retire_cnt), 64'd1);

    // Fill with the port stalled; the fifth push is held off.
    for (int i = 1; i <= 5; i++)
      drive(1'b1, 3'(i % 4), 1'b1, 5'(i + 2), 32'h100 * i, 1'b0, 1'b0);
    chk("full_not_ready", 64'(wbu_ready), 64'd0);
    for (int i = 0; i < 5; i++) idle(1'b1);

    // Write to x0 retires without writing and never marks busy.
    drive(1'b1, 3'd1, 1'b1, 5'd0, 32'h55, 1'b0, 1'b0);
    idle(1'b1);
    idle(1'b1);

    // Flush with a concurrent valid input.
    for (int i = 0; i < 3; i++)
      drive(1'b1, 3'd0, 1'b1, 5'(10 + i), 32'h700 + i, 1'b0, 1'b0);
    drive(1'b1, 3'd3, 1'b1, 5'd20, 32'h999, 1'b1, 1'b1);
    idle(1'b1);
    chk("flush_empty", 64'(sys_valid), 64'd0);

    // Unknown source, PC source, CSR source, and a non-writing entry.
    drive(1'b1, 3'd5, 1'b1, 5'd7, 32'hFFFF, 1'b1, 1'b0);
    drive(1'b1, 3'd2, 1'b1, 5'd8, 32'h8000_0000, 1'b1, 1'b0);
    drive(1'b1, 3'd3, 1'b1, 5'd9, 32'h1111_0000, 1'b1, 1'b0);
    drive(1'b1, 3'd0, 1'b0, 5'd4, 32'hBEEF, 1'b1, 1'b0);
    idle(1'b1);
    idle(1'b1);

    // Counter wrap: 17 retirements on a 4-bit counter.
    do_reset();
    idle(1'b1);
    for (int i = 0; i < 17; i++)
      drive(1'b1, 3'd0, 1'b1, 5'(1 + i % 31), 32'h2000 + i, 1'b1, 1'b0);
    idle(1'b1);
    idle(1'b1);
    chk("wrap17", 64'(retire_cnt), 64'd1);

    // Reset mid-stream with two buffered entries.
    drive(1'b1, 3'd0, 1'b1, 5'd3, 32'h33, 1'b0, 1'b0);
    drive(1'b1, 3'd0, 1'b1, 5'd6, 32'h66, 1'b0, 1'b0);
    do_reset();
    idle(1'b1);
    chk("rst_mask", 64'(busy_mask), 64'd0);

    // Random traffic with occasional flushes.
    for (int i = 0; i < 80; i++)
      drive(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)),
            1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)), $urandom,
            1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 15) == 0));
    for (int i = 0; i < 6; i++) idle(1'b1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
